mmu09_clkgen: RTL and testbench

Synthesizable clock, reset and interrupt sequencer for the MMU09 SBC.
- Derives the 6809 quadrature Q/E clocks from one fast clock, with a parametrised divide ratio.
- Stretches the board reset so the CPU sees reset_n low for a set number of E cycles.
- Drives NCHAN programmable one-shot interrupt channels (NMI/FIRQ/IRQ, …), each fired at a chosen E-cycle count for a chosen length.
- Sits between the board oscillator and the CPU/MMU; usable both in FPGA builds and as a test-bench stimulus source.

---
 rtl/mmu09_pkg.sv | 20 ++
 rtl/mmu09_int_chan.sv | 58 +++++
 rtl/mmu09_clkgen.sv | 115 +++++++++++
 tb/tb_mmu09_clkgen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mmu09_pkg.sv
// Shared definitions for the MMU09 clock, reset and interrupt sequencer.
// Holds the quadrature phase encoding and the channel-index convention.
package mmu09_pkg;

    typedef enum logic [1:0] {
        PH_QR = 2'd0,
        PH_ER = 2'd1,
        PH_QF = 2'd2,
        PH_EF = 2'd3
    } phase_t;

    localparam int CH_NMI  = 0;
    localparam int CH_FIRQ = 1;
    localparam int CH_IRQ  = 2;

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/mmu09_int_chan.sv
// One programmable one-shot interrupt channel: arm register, fire compare,
// remaining-length counter and the registered active-low interrupt line.
module mmu09_int_chan #(
    parameter int CNT_W = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [CNT_W-1:0] at,
    input  logic [LEN_W-1:0] len,
    input  logic             ef_tick,
    input  logic [CNT_W-1:0] ecount_next,
    input  logic             rn_next,
    output logic             int_n
);

    logic             armed_r;
    logic             pulsing_r;
    logic             int_n_r;
    logic [CNT_W-1:0] at_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] rem_r;

    // Channel state: a write always wins over firing or counting on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_r   <= 1'b0;
            pulsing_r <= 1'b0;
            int_n_r   <= 1'b1;
            at_r      <= '0;
            len_r     <= '0;
            rem_r     <= '0;
        end else if (we) begin
            at_r      <= at;
            len_r     <= len;
            armed_r   <= (len != '0);
            pulsing_r <= 1'b0;
            int_n_r   <= 1'b1;
        end else if (ef_tick) begin
            if (pulsing_r) begin
                rem_r <= rem_r - LEN_W'(1);
                if (rem_r == LEN_W'(1)) begin
                    pulsing_r <= 1'b0;
                    int_n_r   <= 1'b1;
                end
            end else if (armed_r && rn_next && (ecount_next == at_r)) begin
                armed_r   <= 1'b0;
                pulsing_r <= 1'b1;
                int_n_r   <= 1'b0;
                rem_r     <= len_r;
            end
        end
    end

    assign int_n = int_n_r;

endmodule

// File: rtl/mmu09_clkgen.sv
// MMU09 sequencer top: fast-clock divider to 6809 Q/E quadrature clocks,
// stretched CPU reset and NCHAN one-shot interrupt channels.
module mmu09_clkgen
    import mmu09_pkg::*;
#(
    parameter int QUARTER_DIV   = 1,
    parameter int RESET_ECYCLES = 4,
    parameter int NCHAN         = 3,
    parameter int CNT_W         = 32,
    parameter int LEN_W         = 8,
    parameter int CH_W          = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_chan,
    input  logic [CNT_W-1:0] cfg_at,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             qclk,
    output logic             eclk,
    output logic             reset_n,
    output logic [NCHAN-1:0] int_n,
    output logic [CNT_W-1:0] ecount,
    output logic             e_fall
);

    localparam int DIV_W = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;

    logic [DIV_W-1:0] div_r;
    phase_t           phase_r;
    logic             qclk_r;
    logic             eclk_r;
    logic             e_fall_r;
    logic             reset_n_r;
    logic [CNT_W-1:0] ecount_r;

    logic             tick_s;
    logic             ef_tick_s;
    logic             rn_next_s;
    logic [CNT_W-1:0] ecount_next_s;

    // Tick decode and the value reset_n takes on this edge; channels need both.
    always_comb begin
        tick_s        = (div_r == DIV_W'(QUARTER_DIV - 1));
        ef_tick_s     = tick_s && (phase_r == PH_EF);
        ecount_next_s = ecount_r + CNT_W'(1);
        if (reset_n_r) begin
            rn_next_s = 1'b1;
        end else if (RESET_ECYCLES == 0) begin
            rn_next_s = 1'b1;
        end else begin
            rn_next_s = ef_tick_s && (ecount_next_s == CNT_W'(RESET_ECYCLES));
        end
    end

    // Divider, phase stepping, clock outputs, E-cycle counter and reset stretch.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r     <= '0;
            phase_r   <= PH_QR;
            qclk_r    <= 1'b0;
            eclk_r    <= 1'b0;
            e_fall_r  <= 1'b0;
            reset_n_r <= 1'b0;
            ecount_r  <= '0;
        end else begin
            e_fall_r  <= ef_tick_s;
            reset_n_r <= rn_next_s;
            if (tick_s) begin
                div_r   <= '0;
                phase_r <= next_phase(phase_r);
                case (phase_r)
                    PH_QR:   qclk_r <= 1'b1;
                    PH_ER:   eclk_r <= 1'b1;
                    PH_QF:   qclk_r <= 1'b0;
                    PH_EF: begin
                        eclk_r   <= 1'b0;
                        ecount_r <= ecount_next_s;
                    end
                    default: qclk_r <= 1'b0;
                endcase
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic we_s;
        // Out-of-range channel indices match no instance and are dropped.
        assign we_s = cfg_we && (cfg_chan == CH_W'(i));

        mmu09_int_chan #(
            .CNT_W(CNT_W),
            .LEN_W(LEN_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .we         (we_s),
            .at         (cfg_at),
            .len        (cfg_len),
            .ef_tick    (ef_tick_s),
            .ecount_next(ecount_next_s),
            .rn_next    (rn_next_s),
            .int_n      (int_n[i])
        );
    end

    assign qclk    = qclk_r;
    assign eclk    = eclk_r;
    assign reset_n = reset_n_r;
    assign ecount  = ecount_r;
    assign e_fall  = e_fall_r;

endmodule

// File: tb/tb_mmu09_clkgen.sv
// Self-checking bench for mmu09_clkgen: an edge-count reference model predicts
// every output each cycle; directed scenarios plus random channel writes.
module tb_mmu09_clkgen;

    localparam int     QD  = 3;
    localparam int     RE  = 4;
    localparam int     NC  = 3;
    localparam int     CW  = 10;
    localparam longint M   = 1024;
    localparam longint M1  = 256;

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [1:0]    cfg_chan;
    logic [CW-1:0] cfg_at;
    logic [7:0]    cfg_len;
    logic          qclk, eclk, reset_n, e_fall;
    logic [NC-1:0] int_n;
    logic [CW-1:0] ecount;

    logic          qclk1, eclk1, reset_n1, e_fall1;
    logic [0:0]    int_n1;
    logic [7:0]    ecount1;

    mmu09_clkgen #(.QUARTER_DIV(QD), .RESET_ECYCLES(RE), .NCHAN(NC), .CNT_W(CW), .LEN_W(8)) u0 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_at(cfg_at),
        .cfg_len(cfg_len), .qclk(qclk), .eclk(eclk), .reset_n(reset_n), .int_n(int_n),
        .ecount(ecount), .e_fall(e_fall)
    );

    mmu09_clkgen #(.QUARTER_DIV(1), .RESET_ECYCLES(0), .NCHAN(1), .CNT_W(8), .LEN_W(8)) u1 (
        .clk(clk), .reset(reset), .cfg_we(1'b0), .cfg_chan(1'b0), .cfg_at(8'd0),
        .cfg_len(8'd0), .qclk(qclk1), .eclk(eclk1), .reset_n(reset_n1), .int_n(int_n1),
        .ecount(ecount1), .e_fall(e_fall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: clk edges since reset release, and one scheduled pulse per channel
    // expressed in absolute (non-wrapping) E-cycle numbers.
    longint n;
    bit     started;
    bit     armed_m [NC];
    longint fire_m  [NC];
    longint len_m   [NC];
    int     pass_cnt;
    int     total_cnt;

    function automatic longint e_abs();
        return (n / QD) / 4;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d after release)", nm, act, exp, n);
    endtask

    task automatic model_update();
        longint e, d, cand;
        if (reset) begin
            n = 0;
            started = 1'b1;
            for (int c = 0; c < NC; c++) armed_m[c] = 1'b0;
        end else begin
            n++;
            e = e_abs();
            if (cfg_we && (int'(cfg_chan) < NC)) begin
                d    = (longint'(cfg_at) - ((e + 1) % M) + M) % M;
                cand = e + 1 + d;
                while (cand < RE) cand += M;
                armed_m[cfg_chan] = (cfg_len != 8'd0);
                fire_m[cfg_chan]  = cand;
                len_m[cfg_chan]   = longint'(cfg_len);
            end
        end
    endtask

    task automatic compare();
        longint t, p, e, exp_int;
        t = n / QD;
        p = t % 4;
        e = e_abs();
        exp_int = 0;
        for (int c = 0; c < NC; c++)
            if (!(armed_m[c] && e >= fire_m[c] && e < fire_m[c] + len_m[c])) exp_int |= (64'd1 << c);
        chk("qclk",    longint'(qclk),    longint'(p == 1 || p == 2));
        chk("eclk",    longint'(eclk),    longint'(p == 2 || p == 3));
        chk("e_fall",  longint'(e_fall),  longint'(t > 0 && p == 0 && (n % QD) == 0));
        chk("reset_n", longint'(reset_n), longint'(n >= 1 && e >= RE));
        chk("ecount",  longint'(ecount),  e % M);
        chk("int_n",   longint'(int_n),   exp_int);
        chk("qclk_d1",    longint'(qclk1),    longint'((n % 4) == 1 || (n % 4) == 2));
        chk("eclk_d1",    longint'(eclk1),    longint'((n % 4) == 2 || (n % 4) == 3));
        chk("e_fall_d1",  longint'(e_fall1),  longint'(n > 0 && (n % 4) == 0));
        chk("reset_n_d1", longint'(reset_n1), longint'(n >= 1));
        chk("ecount_d1",  longint'(ecount1),  (n / 4) % M1);
        chk("int_n_d1",   longint'(int_n1),   64'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (started) compare();
    endtask

    task automatic wr(input int ch, input longint at, input int len);
        cfg_we   = 1'b1;
        cfg_chan = 2'(ch);
        cfg_at   = CW'(at);
        cfg_len  = 8'(len);
        cycle();
        cfg_we   = 1'b0;
    endtask

    task automatic run_until(input longint target);
        int i;
        for (i = 0; i < 20000 && (e_abs() % M) != target; i++) cycle();
        chk("wait_ecount", e_abs() % M, target);
    endtask

    logic [3:0] lit_q, lit_e, lit_f;

    initial begin
        pass_cnt = 0; total_cnt = 0; started = 1'b0; n = 0;
        reset = 1'b1; cfg_we = 1'b0; cfg_chan = 2'd0; cfg_at = '0; cfg_len = 8'd0;
        for (int c = 0; c < NC; c++) begin armed_m[c] = 1'b0; fire_m[c] = 0; len_m[c] = 0; end
        repeat (3) cycle();
        chk("rst_int_n", longint'(int_n), 64'd7);
        chk("rst_reset_n", longint'(reset_n), 64'd0);
        reset = 1'b0;

        // Divide-by-1 quadrature pattern pinned by literals for the first E period.
        lit_q = 4'b0011; lit_e = 4'b0110; lit_f = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("lit_q1", longint'(qclk1),  longint'(lit_q[k]));
            chk("lit_e1", longint'(eclk1),  longint'(lit_e[k]));
            chk("lit_f1", longint'(e_fall1), longint'(lit_f[k]));
        end

        // Pulse on ch2, rewritten mid-pulse; reset stretch pinned at edge 48.
        wr(2, 10, 8);
        while (n < 47) cycle();
        chk("lit_rn_47", longint'(reset_n), 64'd0);
        cycle();
        chk("lit_rn_48", longint'(reset_n), 64'd1);
        chk("lit_ec_48", longint'(ecount), 64'd4);
        run_until(12);
        chk("lit_ch2_low", longint'(int_n[2]), 64'd0);
        wr(2, 40, 2);
        chk("lit_ch2_abort", longint'(int_n[2]), 64'd1);
        run_until(43);

        // Two channels, same start, different lengths; then a len=0 abort.
        wr(1, 50, 3);
        wr(2, 50, 5);
        run_until(50);
        chk("lit_ch12_low", longint'(int_n), 64'd1);
        run_until(52);
        wr(2, 0, 0);
        run_until(53);
        chk("lit_ch1_end", longint'(int_n), 64'd7);
        run_until(60);

        wr(0, 'h1C4, 1);
        wr(3, 'h1C4, 4);
        run_until('h1C4);
        chk("lit_ch0_low", longint'(int_n), 64'd6);
        run_until('h1C5);
        chk("lit_ch0_end", longint'(int_n), 64'd7);

        // Reset mid-pulse.
        wr(1, 'h1D0, 10);
        run_until('h1D4);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("lit_mid_int_n", longint'(int_n), 64'd7);
        chk("lit_mid_ec", longint'(ecount), 64'd0);
        chk("lit_mid_rn", longint'(reset_n), 64'd0);
        chk("lit_mid_q", longint'(qclk), 64'd0);
        wr(0, 2, 2);
        run_until(21);

        // Random writes across a full ecount wrap.
        for (int it = 0; it < 12800; it++) begin
            if ($urandom_range(0, 149) == 0)
                wr(int'($urandom_range(1, 3)), (e_abs() + longint'($urandom_range(0, 30))) % M,
                   int'($urandom_range(0, 6)));
            else
                cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
